// File: rtl/clint_reg_arb.sv
// Round-robin arbiter and sequencer sharing the CLINT register file (msip, mtimecmp, mtime)
// between several simple register-bus requesters. One transaction is in flight at a time:
// accept in IDLE, decode and touch the register file in ACCESS, hold the response in RESP.
module clint_reg_arb #(
  parameter int unsigned REQ_NUM  = 2,
  parameter int unsigned HART_NUM = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_NUM-1:0]         req_valid,
  output logic [REQ_NUM-1:0]         req_ready,
  input  logic [REQ_NUM-1:0]         req_we,
  input  logic [REQ_NUM*ADDR_W-1:0]  req_addr,
  input  logic [REQ_NUM*32-1:0]      req_wdata,
  output logic [REQ_NUM-1:0]         rsp_valid,
  input  logic [REQ_NUM-1:0]         rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic                       mtime_l_wen,
  output logic                       mtime_h_wen,
  output logic [HART_NUM-1:0]        mtimecmp_l_wen,
  output logic [HART_NUM-1:0]        mtimecmp_h_wen,
  output logic [HART_NUM-1:0]        msip_wen,
  output logic [31:0]                reg_wdata,
  input  logic [63:0]                mtime,
  input  logic [64*HART_NUM-1:0]     mtimecmp,
  input  logic [HART_NUM-1:0]        msip
);

  localparam int unsigned IDX_W = $clog2(REQ_NUM);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [IDX_W-1:0]  rr_cand;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_found;

  logic [31:0]       word_off;
  logic              hit;
  logic [31:0]       rd_word;
  logic [HART_NUM-1:0] msip_sel;
  logic [HART_NUM-1:0] cmpl_sel;
  logic [HART_NUM-1:0] cmph_sel;
  logic              mtl_sel;
  logic              mth_sel;
  logic              acc_wr;

  // Round-robin search: first valid requester after the last-served pointer, with wrap-around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_cand   = '0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      rr_cand = IDX_W'((32'(ptr_q) + k) % REQ_NUM);
      if (!gnt_found && req_valid[rr_cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_cand;
      end
    end
  end

  // Byte offset with the two low bits dropped; sub-word offsets alias the containing word.
  assign word_off = 32'(addr_q) & 32'hFFFF_FFFC;

  // Address decode of the latched request into register selects and the read-mux word.
  always_comb begin
    hit      = 1'b0;
    rd_word  = '0;
    msip_sel = '0;
    cmpl_sel = '0;
    cmph_sel = '0;
    mtl_sel  = 1'b0;
    mth_sel  = 1'b0;
    for (int unsigned h = 0; h < HART_NUM; h++) begin
      if (word_off == 32'(4 * h)) begin
        hit         = 1'b1;
        msip_sel[h] = 1'b1;
        rd_word     = {31'b0, msip[h]};
      end
      if (word_off == 32'h4000 + 32'(8 * h)) begin
        hit         = 1'b1;
        cmpl_sel[h] = 1'b1;
        rd_word     = mtimecmp[64*h +: 32];
      end
      if (word_off == 32'h4004 + 32'(8 * h)) begin
        hit         = 1'b1;
        cmph_sel[h] = 1'b1;
        rd_word     = mtimecmp[64*h+32 +: 32];
      end
    end
    if (word_off == 32'h0000_BFF8) begin
      hit     = 1'b1;
      mtl_sel = 1'b1;
      rd_word = mtime[31:0];
    end
    if (word_off == 32'h0000_BFFC) begin
      hit     = 1'b1;
      mth_sel = 1'b1;
      rd_word = mtime[63:32];
    end
  end

  // Write pulses exist only during the single ACCESS cycle, so reset drops them at once.
  assign acc_wr         = (state_q == StAccess) && we_q;
  assign msip_wen       = {HART_NUM{acc_wr}} & msip_sel;
  assign mtimecmp_l_wen = {HART_NUM{acc_wr}} & cmpl_sel;
  assign mtimecmp_h_wen = {HART_NUM{acc_wr}} & cmph_sel;
  assign mtime_l_wen    = acc_wr && mtl_sel;
  assign mtime_h_wen    = acc_wr && mth_sel;

  assign reg_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state logic plus the grant and response-valid strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = StAccess;
        end
      end
      StAccess: begin
        state_d = StResp;
      end
      StResp: begin
        rsp_valid[idx_q] = 1'b1;
        if (rsp_ready[idx_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, request latches, captured response and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(REQ_NUM - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && gnt_found) begin
        idx_q   <= gnt_idx;
        we_q    <= req_we[gnt_idx];
        addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[gnt_idx*32 +: 32];
      end
      if (state_q == StAccess) begin
        // Read data is frozen here so later mtime ticks cannot disturb a pending response.
        err_q   <= !hit;
        rdata_q <= (we_q || !hit) ? 32'h0 : rd_word;
      end
      if (state_q == StResp && rsp_ready[idx_q]) begin
        ptr_q <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_clint_reg_arb.sv
// Self-checking bench for clint_reg_arb: directed vector table, arbitration and reset
// sequences, then randomized traffic against a behavioural address-map model.
module tb_clint_reg_arb;

  localparam int REQ  = 2;
  localparam int HART = 2;
  localparam int AW   = 16;
  localparam logic [63:0] MT = 64'h0000_0012_3456_789A;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [REQ-1:0]       req_valid;
  logic [REQ-1:0]       req_ready;
  logic [REQ-1:0]       req_we;
  logic [REQ*AW-1:0]    req_addr;
  logic [REQ*32-1:0]    req_wdata;
  logic [REQ-1:0]       rsp_valid;
  logic [REQ-1:0]       rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 mtime_l_wen;
  logic                 mtime_h_wen;
  logic [HART-1:0]      mtimecmp_l_wen;
  logic [HART-1:0]      mtimecmp_h_wen;
  logic [HART-1:0]      msip_wen;
  logic [31:0]          reg_wdata;
  logic [63:0]          mtime;
  logic [64*HART-1:0]   mtimecmp;
  logic [HART-1:0]      msip;

  int n_cmp = 0;
  int n_err = 0;
  int last_grant;

  clint_reg_arb #(
    .REQ_NUM (REQ),
    .HART_NUM(HART),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mtime_l_wen   (mtime_l_wen),
    .mtime_h_wen   (mtime_h_wen),
    .mtimecmp_l_wen(mtimecmp_l_wen),
    .mtimecmp_h_wen(mtimecmp_h_wen),
    .msip_wen      (msip_wen),
    .reg_wdata     (reg_wdata),
    .mtime         (mtime),
    .mtimecmp      (mtimecmp),
    .msip          (msip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] e_rdata;
    bit          e_err;
    logic [1:0]  e_msip;
    logic [1:0]  e_cl;
    logic [1:0]  e_ch;
    bit          e_ml;
    bit          e_mh;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic [REQ-1:0] mask, input int last);
    for (int k = 1; k <= REQ; k++) begin
      if (mask[(last + k) % REQ]) return (last + k) % REQ;
    end
    return -1;
  endfunction

  // Behavioural address map: what a transaction should return and which pulse it should make.
  task automatic model(input logic [15:0] a, input bit we, output logic [31:0] rd,
                       output bit err, output logic [1:0] ms, output logic [1:0] cl,
                       output logic [1:0] ch, output bit ml, output bit mh);
    int  off;
    int  h;
    bit  mapped;
    bit  hi;
    off = int'(a) / 4 * 4;
    rd = 32'h0; ms = '0; cl = '0; ch = '0; ml = 1'b0; mh = 1'b0; mapped = 1'b0;
    if (off < 4 * HART) begin
      h = off / 4; mapped = 1'b1;
      if (we) ms[h] = 1'b1;
      else rd = {31'b0, msip[h]};
    end else if (off >= 'h4000 && off < 'h4000 + 8 * HART) begin
      h = (off - 'h4000) / 8; hi = ((off - 'h4000) % 8) == 4; mapped = 1'b1;
      if (we) begin
        if (hi) ch[h] = 1'b1;
        else cl[h] = 1'b1;
      end else begin
        rd = hi ? mtimecmp[64*h+32 +: 32] : mtimecmp[64*h +: 32];
      end
    end else if (off == 'hBFF8) begin
      mapped = 1'b1;
      if (we) ml = 1'b1;
      else rd = mtime[31:0];
    end else if (off == 'hBFFC) begin
      mapped = 1'b1;
      if (we) mh = 1'b1;
      else rd = mtime[63:32];
    end
    err = !mapped;
  endtask

  task automatic set_req(input int r, input bit we, input logic [15:0] a, input logic [31:0] d);
    req_we[r]             = we;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*32 +: 32] = d;
  endtask

  // One full transaction for expected winner g: grant, ACCESS pulses, held response, handshake.
  task automatic run_one(input int g, input bit keep, input int hold,
                         input logic [31:0] e_rdata, input bit e_err, input logic [1:0] e_msip,
                         input logic [1:0] e_cl, input logic [1:0] e_ch, input bit e_ml,
                         input bit e_mh, input logic [31:0] e_wdata);
    int waited;
    bit got;
    got = 1'b0;
    waited = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    chk("grant", 64'(req_ready), 64'(1) << g);
    chk("grant_latency", 64'(waited), 64'(0));
    chk("rsp_idle", 64'(rsp_valid), 64'(0));
    if (!got) return;
    @(posedge clk) #1;
    if (!keep) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("msip_wen", 64'(msip_wen), 64'(e_msip));
    chk("mtimecmp_l_wen", 64'(mtimecmp_l_wen), 64'(e_cl));
    chk("mtimecmp_h_wen", 64'(mtimecmp_h_wen), 64'(e_ch));
    chk("mtime_wen", 64'({mtime_h_wen, mtime_l_wen}), 64'({e_mh, e_ml}));
    chk("reg_wdata", 64'(reg_wdata), 64'(e_wdata));
    chk("ready_access", 64'(req_ready), 64'(0));
    chk("rsp_access", 64'(rsp_valid), 64'(0));
    @(posedge clk) #1;
    mtime = {$urandom, $urandom};
    rsp_ready[g] = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) rsp_ready[g] = 1'b1;
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << g);
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(e_err));
      chk("ready_resp", 64'(req_ready), 64'(0));
      chk("wen_resp", 64'({msip_wen, mtimecmp_l_wen, mtimecmp_h_wen, mtime_l_wen, mtime_h_wen}),
          64'(0));
      @(posedge clk) #1;
    end
    rsp_ready[g] = 1'b0;
    last_grant = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    logic [1:0]  ms, cl, ch;
    bit          ml, mh;
    int          g;
    logic [REQ-1:0] mask;
    logic [15:0] a;

    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    mtime = MT;
    mtimecmp = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
    msip = 2'b10;
    last_grant = REQ - 1;

    tbl[0]  = '{0, 1'b1, 16'h0000, 32'h1,         0, 32'h0,        1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{0, 1'b0, 16'hBFF8, 32'h0,         0, 32'h3456789A, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1, 1'b0, 16'hBFFC, 32'h0,         0, 32'h00000012, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{0, 1'b0, 16'h1000, 32'h0,         0, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{1, 1'b1, 16'h1000, 32'hDEADBEEF,  0, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{0, 1'b0, 16'h4000, 32'h0,         0, 32'h33334444, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1, 1'b0, 16'h400C, 32'h0,         0, 32'hAAAABBBB, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{0, 1'b0, 16'h0004, 32'h0,         0, 32'h1,        1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1, 1'b1, 16'h4008, 32'hCAFEF00D,  0, 32'h0,        1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{0, 1'b1, 16'hBFFE, 32'h00000077,  0, 32'h0,        1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{1, 1'b0, 16'h0008, 32'h0,         0, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{0, 1'b0, 16'h4011, 32'h0,         0, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{0, 1'b1, 16'hBFF8, 32'h12345678,  0, 32'h0,        1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{1, 1'b0, 16'h4004, 32'h0,         5, 32'h11112222, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({req_ready, rsp_valid, msip_wen, mtimecmp_l_wen, mtimecmp_h_wen,
                              mtime_l_wen, mtime_h_wen, rsp_err}), 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_wdata", 64'(reg_wdata), 64'(0));
    @(posedge clk) #1;
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      mtime = MT;
      set_req(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      req_valid = '0;
      req_valid[tbl[i].r] = 1'b1;
      g = exp_grant(req_valid, last_grant);
      run_one(g, 1'b0, tbl[i].hold, tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_msip, tbl[i].e_cl,
              tbl[i].e_ch, tbl[i].e_ml, tbl[i].e_mh, tbl[i].wdata);
    end

    // Both requesters continuously valid: strict alternation.
    set_req(0, 1'b0, 16'hBFF8, 32'h0);
    set_req(1, 1'b0, 16'h0004, 32'h5);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mtime = MT;
      g = exp_grant(req_valid, last_grant);
      model(req_addr[g*AW +: AW], req_we[g], rd, er, ms, cl, ch, ml, mh);
      run_one(g, 1'b1, 0, rd, er, ms, cl, ch, ml, mh, req_wdata[g*32 +: 32]);
    end
    req_valid = '0;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        req_valid = '0;
        @(negedge clk);
        chk("idle_no_ready", 64'(req_ready), 64'(0));
        @(posedge clk) #1;
      end
      mask = REQ'($urandom_range(1, 3));
      msip = HART'($urandom_range(0, 3));
      mtime = {$urandom, $urandom};
      for (int r = 0; r < REQ; r++) begin
        case ($urandom_range(0, 3))
          0: a = 16'(4 * $urandom_range(0, 3));
          1: a = 16'('h4000 + 4 * $urandom_range(0, 5));
          2: a = 16'('hBFF8 + 4 * $urandom_range(0, 1));
          default: a = 16'($urandom);
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        set_req(r, 1'($urandom_range(0, 1)), a, $urandom);
      end
      req_valid = mask;
      g = exp_grant(mask, last_grant);
      model(req_addr[g*AW +: AW], req_we[g], rd, er, ms, cl, ch, ml, mh);
      run_one(g, 1'b0, $urandom_range(0, 2), rd, er, ms, cl, ch, ml, mh, req_wdata[g*32 +: 32]);
    end
    req_valid = '0;

    // Reset during ACCESS of a write: pulse drops at once, pointer returns to its reset value.
    mtime = MT;
    set_req(0, 1'b1, 16'h0000, 32'h1);
    req_valid = 2'b01;
    g = exp_grant(req_valid, last_grant);
    run_one(g, 1'b0, 0, 32'h0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h1);
    set_req(0, 1'b1, 16'h4000, 32'h55AA55AA);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_seq_grant", 64'(req_ready), 64'(1));
    @(posedge clk) #1;
    req_valid = '0;
    @(negedge clk);
    chk("rst_seq_wen", 64'(mtimecmp_l_wen), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_wen", 64'(mtimecmp_l_wen), 64'(0));
    chk("rst_async_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_async_wdata", 64'(reg_wdata), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk) #1;
    rst_n = 1'b1;
    last_grant = REQ - 1;
    set_req(0, 1'b0, 16'hBFFC, 32'h0);
    set_req(1, 1'b0, 16'hBFF8, 32'h0);
    req_valid = 2'b11;
    g = exp_grant(req_valid, last_grant);
    model(req_addr[g*AW +: AW], req_we[g], rd, er, ms, cl, ch, ml, mh);
    run_one(g, 1'b0, 0, rd, er, ms, cl, ch, ml, mh, req_wdata[g*32 +: 32]);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clint_reg_arb.md
Name: clint_reg_arb

Overview:
- Round-robin arbiter and sequencer that shares the CLINT register file (mtime, mtimecmp, msip) between REQ_NUM simple register-bus requesters, e.g. the AXI bridge and a debug/time-sync agent.
- Accepts one request at a time, decodes the address to per-register write-enable pulses and read-mux selects, and returns a response to the granted requester.
- Sits between the requesters and clint_core, in place of a single bridge driving the core.

Parameters:
- REQ_NUM, 2, number of requesters (≥2).
- HART_NUM, 1, number of harts (msip/mtimecmp instances).
- ADDR_W, 16, register offset width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  REQ_NUM  per-requester request valid
- req_ready  out  REQ_NUM  per-requester request accept
- req_we  in  REQ_NUM  1=write, 0=read
- req_addr  in  REQ_NUM*ADDR_W  byte offset, requester i at slice i
- req_wdata  in  REQ_NUM*32  write data
- rsp_valid  out  REQ_NUM  response valid
- rsp_ready  in  REQ_NUM  response accept
- rsp_rdata  out  32  read data (shared, qualified by rsp_valid)
- rsp_err  out  1  unmapped address flag
- mtime_l_wen / mtime_h_wen  out  1  mtime word write pulses
- mtimecmp_l_wen / mtimecmp_h_wen  out  HART_NUM  per-hart mtimecmp word write pulses
- msip_wen  out  HART_NUM  per-hart msip write pulse
- reg_wdata  out  32  write data to core
- mtime  in  64  current mtime
- mtimecmp  in  64*HART_NUM  per-hart compare values
- msip  in  HART_NUM  current msip bits

Behaviour:
- Address map:
  - msip[h] = 0x0000+4h
  - mtimecmp[h] low/high = 0x4000+8h / +4
  - mtime low/high = 0xBFF8 / 0xBFFC
  - addr[1:0] ignored
  - all other offsets unmapped
- FSM states IDLE, ACCESS, RESP. Reset: IDLE, rr pointer = REQ_NUM-1 (requester 0 wins first), all outputs 0.
- IDLE:
  - req_ready is the one-hot round-robin grant: the first asserted req_valid searching from pointer+1 with wrap-around.
  - On a grant, latch index, we, addr and wdata; go to ACCESS. No valid requests: stay in IDLE with req_ready=0.
  - req_ready is never asserted outside IDLE.
- ACCESS (exactly 1 cycle):
  - Mapped write: the single matching wen is high for this cycle only; reg_wdata = latched wdata (driven from latch, stable in all states).
  - Read: capture the selected word into the rdata register. msip reads return {31'b0,msip[h]}.
  - Unmapped: no wen; rdata=0, err=1. Writes return rdata=0.
  - Go to RESP.
- RESP:
  - rsp_valid[granted]=1, rsp_rdata and rsp_err stable, until rsp_ready[granted]. Other rsp_valid bits stay 0.
  - On the handshake: pointer := granted index, go to IDLE. The next grant can occur the following cycle.
- Latency: accept at cycle T, wen at T+1, rsp_valid at T+2 at the earliest. Max throughput is one op per 3 cycles.
- Read data is captured in ACCESS; later mtime changes do not alter a pending response.
- A requester may deassert req_valid while not granted, with no effect.
- Simultaneous requests are served strictly round-robin. No starvation: each waiting requester is served within REQ_NUM transactions.
- Reset mid-operation clears the FSM and latches immediately; a pending wen or rsp_valid drops asynchronously.

Test Plan:
- Write 0x1 to 0x0000 from req0 → msip_wen[0] pulses 1 cycle with reg_wdata=1 exactly 1 cycle after accept; rsp_valid[0] on the next cycle with rsp_err=0.
- Read 0xBFF8 then 0xBFFC with core mtime=0x0000_0012_3456_789A → rdata 0x3456789A then 0x00000012.
- req0 and req1 both valid continuously for 4 transactions → grant order 0,1,0,1; req_ready never 2-hot.
- Read 0x1000 (unmapped) → rsp_err=1, rdata=0. Write to 0x1000 → no wen asserted.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rdata stable, no new req_ready. Release → IDLE next cycle.
- Assert rst_n=0 during ACCESS of a write → wen drops immediately, rsp_valid never asserts. After reset, requester 0 is granted first.
